// File: rtl/lt_cap_pkg.sv
// rtl/lt_cap_pkg.sv - shared types and constants for the loop_test response capture stage
package lt_cap_pkg;

  localparam int          LT_RESP_W       = 6;
  localparam logic [15:0] POLY_CCITT      = 16'h1021;
  localparam logic [5:0]  LT_MASK_DEFAULT = 6'h27;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    SETTLE,
    SAMPLE,
    DONE
  } cap_state_e;

endpackage

// File: rtl/loop_test_resp_capture_if.sv
// rtl/loop_test_resp_capture_if.sv - vector handshake and response bus between upstream and capture stage
interface loop_test_resp_capture_if import lt_cap_pkg::*; ();

  logic                 vec_valid;
  logic                 vec_ready;
  logic [LT_RESP_W-1:0] resp;

  modport master (output vec_valid, output resp, input vec_ready);
  modport slave  (input vec_valid, input resp, output vec_ready);

endinterface

// File: rtl/lt_misr16.sv
// rtl/lt_misr16.sv - 16-bit multiple-input signature register with synchronous load
module lt_misr16 import lt_cap_pkg::*; #(
  parameter logic [15:0] POLY    = POLY_CCITT,
  parameter logic [15:0] RST_VAL = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        en,
  input  logic [15:0] din,
  output logic [15:0] sig
);

  logic [15:0] sig_q;
  logic [15:0] sig_d;

  // Load has priority; otherwise shift with polynomial feedback and fold in the data word.
  always_comb begin
    sig_d = sig_q;
    if (load) begin
      sig_d = load_val;
    end else if (en) begin
      sig_d = {sig_q[14:0], 1'b0} ^ (sig_q[15] ? POLY : 16'h0000) ^ din;
    end
  end

  // Signature register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sig_q <= RST_VAL;
    else        sig_q <= sig_d;
  end

  assign sig = sig_q;

endmodule

// File: rtl/loop_test_resp_capture.sv
// rtl/loop_test_resp_capture.sv - settle, toggle-watch and MISR-compress the loop_test DUT response
module loop_test_resp_capture import lt_cap_pkg::*; #(
  parameter int unsigned SETTLE_CYC  = 8,
  parameter int unsigned MAX_TOGGLES = 2,
  parameter int unsigned NUM_VEC     = 16,
  parameter logic [5:0]  RESP_MASK   = LT_MASK_DEFAULT,
  parameter logic [15:0] SEED        = 16'h0000,
  parameter logic [15:0] POLY        = POLY_CCITT
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  loop_test_resp_capture_if.slave       bus,
  output logic [15:0]                   signature,
  output logic                          unstable,
  output logic [7:0]                    vec_count,
  output logic                          done
);

  // Counter only needs to hold SETTLE_CYC-1.
  localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  cap_state_e           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [LT_RESP_W-1:0] prev_q, prev_d;
  logic [3:0]           tog_q, tog_d;
  logic                 unstable_q, unstable_d;
  logic [7:0]           vec_count_q, vec_count_d;
  logic                 misr_load, misr_en;
  logic [LT_RESP_W-1:0] m;

  assign m = bus.resp & RESP_MASK;

  // Next-state and datapath control; start overrides every other event.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    prev_d      = prev_q;
    tog_d       = tog_q;
    unstable_d  = unstable_q;
    vec_count_d = vec_count_q;
    misr_load   = 1'b0;
    misr_en     = 1'b0;
    if (start) begin
      state_d     = ARMED;
      misr_load   = 1'b1;
      unstable_d  = 1'b0;
      vec_count_d = 8'd0;
      cnt_d       = '0;
      prev_d      = '0;
      tog_d       = 4'd0;
    end else begin
      case (state_q)
        ARMED: begin
          if (bus.vec_valid) begin
            cnt_d   = CNT_W'(SETTLE_CYC - 1);
            prev_d  = m;
            tog_d   = 4'd0;
            state_d = SETTLE;
          end
        end
        SETTLE: begin
          if ((m != prev_q) && (tog_q != 4'hF)) tog_d = tog_q + 4'd1;
          prev_d = m;
          if (cnt_q == '0) state_d = SAMPLE;
          else             cnt_d   = cnt_q - 1'b1;
        end
        SAMPLE: begin
          misr_en     = 1'b1;
          if (32'(tog_q) > MAX_TOGGLES) unstable_d = 1'b1;
          vec_count_d = vec_count_q + 8'd1;
          state_d     = (vec_count_d == 8'(NUM_VEC)) ? DONE : ARMED;
        end
        IDLE, DONE: ;
        default: state_d = IDLE;
      endcase
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      prev_q      <= '0;
      tog_q       <= 4'd0;
      unstable_q  <= 1'b0;
      vec_count_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      prev_q      <= prev_d;
      tog_q       <= tog_d;
      unstable_q  <= unstable_d;
      vec_count_q <= vec_count_d;
    end
  end

  lt_misr16 #(.POLY(POLY), .RST_VAL(SEED)) u_misr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (misr_load),
    .load_val (SEED),
    .en       (misr_en),
    .din      ({10'b0, m}),
    .sig      (signature)
  );

  assign bus.vec_ready = (state_q == ARMED);
  assign done          = (state_q == DONE);
  assign unstable      = unstable_q;
  assign vec_count     = vec_count_q;

endmodule

// File: tb/tb_loop_test_resp_capture.sv
// tb/tb_loop_test_resp_capture.sv - self-checking bench for loop_test_resp_capture
module tb_loop_test_resp_capture;
  import lt_cap_pkg::*;

  localparam int S = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_a, start_b;
  logic [15:0] sig_a, sig_b;
  logic        unst_a, unst_b, done_a, done_b;
  logic [7:0]  cnt_a, cnt_b;

  loop_test_resp_capture_if ia ();
  loop_test_resp_capture_if ib ();

  loop_test_resp_capture #(.RESP_MASK(6'h3F)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .bus(ia),
    .signature(sig_a), .unstable(unst_a), .vec_count(cnt_a), .done(done_a)
  );

  loop_test_resp_capture #(.NUM_VEC(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .bus(ib),
    .signature(sig_b), .unstable(unst_b), .vec_count(cnt_b), .done(done_b)
  );

  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  logic [5:0]  vbuf [0:S+1];
  logic [15:0] e_sig  [2];
  logic        e_unst [2];
  int          e_cnt  [2];

  function automatic logic [5:0] mask_of(input bit sel);
    return sel ? 6'h27 : 6'h3F;
  endfunction

  function automatic int nvec_of(input bit sel);
    return sel ? 2 : 16;
  endfunction

  // Signature update as polynomial division: multiply by x, reduce mod x^16+x^12+x^5+1, add data.
  function automatic logic [15:0] misr_ref(input logic [15:0] s, input logic [5:0] m);
    logic [16:0] w;
    w = {s, 1'b0};
    if (w[16]) w = w ^ 17'h11021;
    return w[15:0] ^ {10'h000, m};
  endfunction

  function automatic logic [31:0] o_sig(input bit sel);  return sel ? 32'(sig_b)  : 32'(sig_a);  endfunction
  function automatic logic [31:0] o_cnt(input bit sel);  return sel ? 32'(cnt_b)  : 32'(cnt_a);  endfunction
  function automatic logic [31:0] o_unst(input bit sel); return sel ? 32'(unst_b) : 32'(unst_a); endfunction
  function automatic logic [31:0] o_done(input bit sel); return sel ? 32'(done_b) : 32'(done_a); endfunction
  function automatic logic [31:0] o_rdy(input bit sel);  return sel ? 32'(ib.vec_ready) : 32'(ia.vec_ready); endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic v, input logic [5:0] r);
    if (sel) begin ib.vec_valid = v; ib.resp = r; end
    else     begin ia.vec_valid = v; ia.resp = r; end
  endtask

  task automatic fill_held(input logic [5:0] v);
    for (int k = 0; k <= S + 1; k++) vbuf[k] = v;
  endtask

  // Called at a negedge; pulses start for one cycle and checks the re-armed state.
  task automatic do_start(input bit sel);
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0;
    e_sig[sel] = 16'h0000; e_unst[sel] = 1'b0; e_cnt[sel] = 0;
    chk("start_ready", o_rdy(sel), 1);
    chk("start_count", o_cnt(sel), 0);
    chk("start_sig",   o_sig(sel), 0);
    chk("start_done",  o_done(sel), 0);
  endtask

  // Called at a negedge with the DUT armed; applies vbuf[k] for the k-th cycle after the handshake.
  task automatic run_vec(input bit sel);
    int tog;
    chk("rdy_pre", o_rdy(sel), 1);
    drive(sel, 1'b1, vbuf[0]);
    for (int k = 1; k <= S + 1; k++) begin
      @(negedge clk);
      drive(sel, 1'b0, vbuf[k]);
      if (k == 1)     chk("rdy_busy", o_rdy(sel), 0);
      if (k == S + 1) chk("sig_hold", o_sig(sel), 32'(e_sig[sel]));
    end
    @(negedge clk);
    tog = 0;
    for (int i = 1; i <= S; i++)
      if (((vbuf[i] ^ vbuf[i-1]) & mask_of(sel)) != 6'h00) tog++;
    e_sig[sel] = misr_ref(e_sig[sel], vbuf[S+1] & mask_of(sel));
    if (tog > 2) e_unst[sel] = 1'b1;
    e_cnt[sel]++;
    chk("sig",      o_sig(sel),  32'(e_sig[sel]));
    chk("count",    o_cnt(sel),  32'(e_cnt[sel]));
    chk("unstable", o_unst(sel), 32'(e_unst[sel]));
    chk("done",     o_done(sel), (e_cnt[sel] == nvec_of(sel)) ? 1 : 0);
    chk("rdy_post", o_rdy(sel),  (e_cnt[sel] == nvec_of(sel)) ? 0 : 1);
  endtask

  task automatic check_ignored(input bit sel);
    logic [31:0] s0;
    s0 = o_sig(sel);
    for (int k = 0; k < 4; k++) begin
      drive(sel, 1'b1, 6'($urandom));
      @(negedge clk);
    end
    drive(sel, 1'b0, 6'h00);
    chk("ign_count", o_cnt(sel),  32'(e_cnt[sel]));
    chk("ign_sig",   o_sig(sel),  s0);
    chk("ign_done",  o_done(sel), 1);
    chk("ign_ready", o_rdy(sel),  0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
    drive(0, 1'b0, 6'h00); drive(1, 1'b0, 6'h00);
    #1;
    chk("rst_sig",   o_sig(0),  0);
    chk("rst_unst",  o_unst(0), 0);
    chk("rst_count", o_cnt(0),  0);
    chk("rst_done",  o_done(0), 0);
    chk("rst_ready", o_rdy(0),  0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", o_rdy(0), 0);

    // DUT A: full mask, 16 vectors
    do_start(0);
    fill_held(6'h01); run_vec(0);
    chk("a_v1_const", o_sig(0), 32'h0001);
    fill_held(6'h21); run_vec(0);
    chk("a_v2_const", o_sig(0), 32'h0023);
    chk("a_v2_stable", o_unst(0), 0);
    for (int k = 0; k <= S + 1; k++) vbuf[k] = (k % 2 == 1) ? 6'h01 : 6'h00;
    run_vec(0);
    chk("a_toggle_unst", o_unst(0), 1);
    fill_held(6'h05); run_vec(0);
    chk("a_sticky_unst", o_unst(0), 1);
    for (int n = 0; n < 12; n++) begin
      logic [5:0] base;
      base = 6'($urandom);
      for (int k = 0; k <= S + 1; k++) begin
        if ($urandom_range(3) == 0) base = 6'($urandom);
        vbuf[k] = base;
      end
      run_vec(0);
    end
    chk("a_done", o_done(0), 1);
    check_ignored(0);

    // DUT B: default mask, 2 vectors per run
    do_start(1);
    fill_held(6'h18); run_vec(1);
    chk("b_masked_sig", o_sig(1), 32'h0000);
    fill_held(6'h3F); run_vec(1);
    chk("b_v2_sig", o_sig(1), 32'h0027);
    chk("b_done", o_done(1), 1);
    check_ignored(1);
    do_start(1);
    fill_held(6'h01); run_vec(1);
    chk("b_rerun_sig", o_sig(1), 32'h0001);
    drive(1, 1'b1, 6'h01);
    @(negedge clk); drive(1, 1'b0, 6'h01);
    @(negedge clk); @(negedge clk);
    do_start(1);
    fill_held(6'h21); run_vec(1);
    chk("b_abort_sig", o_sig(1), 32'h0021);
    chk("b_abort_cnt", o_cnt(1), 1);

    // Asynchronous reset while A is done and B is mid-settle
    drive(1, 1'b1, 6'h07);
    @(negedge clk); drive(1, 1'b0, 6'h07);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_a_sig",   o_sig(0),  0);
    chk("arst_a_unst",  o_unst(0), 0);
    chk("arst_a_count", o_cnt(0),  0);
    chk("arst_a_done",  o_done(0), 0);
    chk("arst_b_sig",   o_sig(1),  0);
    chk("arst_b_count", o_cnt(1),  0);
    chk("arst_b_ready", o_rdy(1),  0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
